// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//
// Shared definitions for the HI/LO multiply/divide unit:
//   - operation codes presented on the Op input
//   - FSM state type used by hilo_muldiv_unit
//   - fixed result patterns for divide-by-zero and signed divide overflow
//
// The result constants are 64 bits wide (the widest legal operand width)
// and are sliced down to WIDTH by the user.
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Divide by zero: LO is all ones, HI returns the dividend unchanged.
    localparam logic [63:0] DIVZ_LO = '1;
    // Signed overflow (most-negative / -1): LO returns the dividend, HI is zero.
    localparam logic [63:0] OVF_HI  = '0;

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//
// One radix-2 iteration of the shared multiply/divide datapath. Purely
// combinational; the owning FSM registers work_out back into work_in.
//
// The 2*WIDTH-bit work register is used as:
//   multiply : {partial product high half, remaining multiplier bits}
//   divide   : {partial remainder, remaining dividend / growing quotient}
//
// Configuration macro: HILO_MULDIV_DIV_EN -- when undefined the trial-subtract
// path (and the is_div port) are not built at all.
//
// Ports:
//   is_div   in   1         select restoring-divide step (only with HILO_MULDIV_DIV_EN)
//   work_in  in   2*WIDTH   current work register
//   opnd     in   WIDTH     multiplicand magnitude or divisor magnitude
//   work_out out  2*WIDTH   work register after one step
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef HILO_MULDIV_DIV_EN
    input  logic               is_div,
`endif
    input  logic [2*WIDTH-1:0] work_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] work_out
);

    logic [WIDTH:0] add_sum;

`ifdef HILO_MULDIV_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_trial_msb;

    // After a successful trial the difference is below the divisor, so it
    // always fits in WIDTH bits and its top bit carries no information.
    assign unused_trial_msb = trial[WIDTH];
`endif

    always_comb begin
        // Shift-add: add the multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole register right, pulling
        // the carry into the top.
        add_sum  = {1'b0, work_in[2*WIDTH-1:WIDTH]} + (work_in[0] ? {1'b0, opnd} : '0);
        work_out = {add_sum, work_in[WIDTH-1:1]};

`ifdef HILO_MULDIV_DIV_EN
        // Restoring divide: shift the next dividend bit into the remainder and
        // try to subtract the divisor; keep the difference only if no borrow.
        shifted = {work_in[2*WIDTH-1:WIDTH], work_in[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, opnd};
        if (is_div) begin
            if (!trial[WIDTH+1]) begin
                work_out = {trial[WIDTH-1:0], work_in[WIDTH-2:0], 1'b1};
            end else begin
                work_out = {shifted[WIDTH-1:0], work_in[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// MIPS-style HI/LO multiply/divide unit. Iterative operations run on
// operand magnitudes for WIDTH cycles, then a single FIX cycle applies the
// sign correction (and MADD/MSUB accumulation) and writes HI/LO. HI/LO are
// therefore only ever updated with final results.
//
// Configuration macro: HILO_MULDIV_DIV_EN -- builds the divider. Without it
// DIV/DIVU are accepted as no-ops that pulse Done the next cycle.
//
// Ports:
//   Clk    in   1      clock, rising edge
//   Rst    in   1      asynchronous active-high reset
//   Start  in   1      operation request, honoured only when idle
//   Op     in   3      operation code (see muldiv_pkg)
//   A, B   in   WIDTH  operands (MTHI/MTLO use A)
//   Hi, Lo out  WIDTH  architectural HI/LO registers
//   Busy   out  1      iterative operation in flight
//   Done   out  1      one-cycle pulse when HI/LO hold a new result
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    import muldiv_pkg::*;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   work;
    logic [2*WIDTH-1:0]   work_nxt;

    logic                 signed_op;
    logic                 in_sa;
    logic                 in_sb;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   hilo_mult;

`ifdef HILO_MULDIV_DIV_EN
    logic [WIDTH-1:0]     a_raw;
    logic                 div_zero;
    logic                 div_ovf;
    logic                 is_div_q;
    logic [WIDTH-1:0]     quot_s;
    logic [WIDTH-1:0]     rem_s;

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
`endif

    // The iteration runs on magnitudes; signs are remembered separately and
    // only signed opcodes ever report a negative operand.
    always_comb begin
        signed_op = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
        in_sa     = signed_op & A[WIDTH-1];
        in_sb     = signed_op & B[WIDTH-1];
        mag_a     = in_sa ? -A : A;
        mag_b     = in_sb ? -B : B;
    end

    // Final multiply result, including the MADD/MSUB accumulation into the
    // HI/LO value that was present when the operation was accepted.
    always_comb begin
        prod_s = (sign_a ^ sign_b) ? -work : work;
        case (op_q)
            OP_MADD: hilo_mult = {Hi, Lo} + prod_s;
            OP_MSUB: hilo_mult = {Hi, Lo} - prod_s;
            default: hilo_mult = prod_s;
        endcase
    end

`ifdef HILO_MULDIV_DIV_EN
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    always_comb begin
        quot_s = (sign_a ^ sign_b) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_s  = sign_a ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    end
`endif

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
`ifdef HILO_MULDIV_DIV_EN
        .is_div   (is_div_q),
`endif
        .work_in  (work),
        .opnd     (opnd),
        .work_out (work_nxt)
    );

    // Control FSM and all architectural state. Done defaults low each cycle
    // so every set below produces exactly a one-cycle pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= OP_MULT;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            opnd     <= '0;
            work     <= '0;
            Hi       <= '0;
            Lo       <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
            a_raw    <= '0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MTHI: begin
                                Hi   <= A;
                                Done <= 1'b1;
                            end
                            OP_MTLO: begin
                                Lo   <= A;
                                Done <= 1'b1;
                            end
`ifndef HILO_MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                Done <= 1'b1;
                            end
`endif
                            default: begin
                                op_q   <= Op;
                                sign_a <= in_sa;
                                sign_b <= in_sb;
                                cnt    <= CNT_W'(WIDTH);
                                Busy   <= 1'b1;
                                state  <= RUN;
`ifdef HILO_MULDIV_DIV_EN
                                a_raw    <= A;
                                div_zero <= (B == '0);
                                div_ovf  <= (Op == OP_DIV) && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
                                if ((Op == OP_DIV) || (Op == OP_DIVU)) begin
                                    work <= {{WIDTH{1'b0}}, mag_a};
                                    opnd <= mag_b;
                                end else
`endif
                                begin
                                    work <= {{WIDTH{1'b0}}, mag_b};
                                    opnd <= mag_a;
                                end
                            end
                        endcase
                    end
                end

                RUN: begin
                    work <= work_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
`ifdef HILO_MULDIV_DIV_EN
                    if (is_div_q) begin
                        if (div_zero) begin
                            Lo <= DIVZ_LO[WIDTH-1:0];
                            Hi <= a_raw;
                        end else if (div_ovf) begin
                            Lo <= a_raw;
                            Hi <= OVF_HI[WIDTH-1:0];
                        end else begin
                            Lo <= quot_s;
                            Hi <= rem_s;
                        end
                    end else
`endif
                    begin
                        Hi <= hilo_mult[2*WIDTH-1:WIDTH];
                        Lo <= hilo_mult[WIDTH-1:0];
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Self-checking bench for hilo_muldiv_unit (WIDTH=32). Expected HI/LO values
// and latencies come from an arithmetic model of the architectural
// registers; whether DIV/DIVU are modelled as real divides or no-ops follows
// the HILO_MULDIV_DIV_EN macro.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam int WIDTH    = 32;
    localparam int ITER_LAT = WIDTH + 2;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] MADD  = 3'b010;
    localparam logic [2:0] MSUB  = 3'b011;
    localparam logic [2:0] DIV   = 3'b100;
    localparam logic [2:0] DIVU  = 3'b101;
    localparam logic [2:0] MTHI  = 3'b110;
    localparam logic [2:0] MTLO  = 3'b111;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_hi;
    logic [WIDTH-1:0] model_lo;

    hilo_muldiv_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    // Architectural model: updates model_hi/model_lo and returns the cycle
    // (counted from the accepting edge) in which Done is expected.
    function automatic int model_exec(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     acc;
        int              qi;
        int              ri;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {model_hi, model_lo};
        qi  = 0;
        ri  = 0;
        case (op)
            MTHI: begin model_hi = a; return 1; end
            MTLO: begin model_lo = a; return 1; end
            MULT:  acc = sa * sb;
            MULTU: acc = ua * ub;
            MADD:  acc = acc + 64'(sa * sb);
            MSUB:  acc = acc - 64'(sa * sb);
            default: begin
`ifdef HILO_MULDIV_DIV_EN
                if (b == 32'd0) begin
                    model_lo = 32'hFFFF_FFFF;
                    model_hi = a;
                end else if (op == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    model_lo = a;
                    model_hi = 32'd0;
                end else if (op == DIV) begin
                    qi = $signed(a) / $signed(b);
                    ri = $signed(a) % $signed(b);
                    model_lo = 32'(qi);
                    model_hi = 32'(ri);
                end else begin
                    model_lo = a / b;
                    model_hi = a % b;
                end
                return ITER_LAT;
`else
                return 1;
`endif
            end
        endcase
        {model_hi, model_lo} = acc;
        return ITER_LAT;
    endfunction

    // Issues one request (called #1 after a rising edge) and follows it to
    // Done. Optionally pulses an MTHI request of poke_a in cycle poke_cyc.
    // Returns the Done cycle (-1 on timeout), whether Busy was seen, and
    // whether Hi/Lo moved before Done. Leaves time at #1 after the Done edge
    // so the next call starts in the Done cycle.
    task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int poke_cyc,
                          input logic [WIDTH-1:0] poke_a, output int cyc,
                          output logic busy_seen, output logic moved);
        logic [WIDTH-1:0] hi0;
        logic [WIDTH-1:0] lo0;
        hi0   = Hi;
        lo0   = Lo;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk); #1;
        Start     = 1'b0;
        cyc       = 1;
        busy_seen = (Busy === 1'b1);
        moved     = 1'b0;
        while (Done !== 1'b1 && cyc <= ITER_LAT + 10) begin
            if (Busy === 1'b1) busy_seen = 1'b1;
            if (Hi !== hi0 || Lo !== lo0) moved = 1'b1;
            if (cyc == poke_cyc) begin
                Start = 1'b1;
                Op    = MTHI;
                A     = poke_a;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk); #1;
            cyc++;
        end
        Start = 1'b0;
        if (Done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        Rst   = 1'b1;
        Start = 1'b0;
        Op    = MULT;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if (Hi !== 32'd0)  begin n_fail++; $display("[TB] FAIL reset_hi: got %h want %h", Hi, 32'd0); end
        n_checks++; if (Lo !== 32'd0)  begin n_fail++; $display("[TB] FAIL reset_lo: got %h want %h", Lo, 32'd0); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", Done); end
        Rst      = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(posedge Clk); #1;
    endtask

    // Directed multiply, MTHI/MTLO and accumulate sequence with known results.
    task automatic test_mult_directed();
        logic [2:0]  t_op [6] = '{MULT, MULTU, MTLO, MTHI, MADD, MSUB};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd4, 32'd4};
        logic [31:0] t_b  [6] = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5, 32'd5};
        logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
        logic [31:0] t_lo [6] = '{32'hFFFF_FFEB, 32'd1, 32'd10, 32'd10, 32'd30, 32'd10};
        int          t_cy [6] = '{ITER_LAT, ITER_LAT, 1, 1, ITER_LAT, ITER_LAT};
        int          cyc;
        logic        busy_seen;
        logic        moved;
        for (int i = 0; i < 6; i++) begin
            void'(model_exec(t_op[i], t_a[i], t_b[i]));
            run_op(t_op[i], t_a[i], t_b[i], 0, '0, cyc, busy_seen, moved);
            n_checks++; if (cyc !== t_cy[i]) begin n_fail++; $display("[TB] FAIL dir_latency[%0d]: got %0d want %0d", i, cyc, t_cy[i]); end
            n_checks++; if (Hi !== t_hi[i]) begin n_fail++; $display("[TB] FAIL dir_hi[%0d]: got %h want %h", i, Hi, t_hi[i]); end
            n_checks++; if (Lo !== t_lo[i]) begin n_fail++; $display("[TB] FAIL dir_lo[%0d]: got %h want %h", i, Lo, t_lo[i]); end
            n_checks++; if (busy_seen !== (t_cy[i] != 1)) begin n_fail++; $display("[TB] FAIL dir_busy[%0d]: got %b want %b", i, busy_seen, (t_cy[i] != 1)); end
            n_checks++; if (moved !== 1'b0) begin n_fail++; $display("[TB] FAIL dir_early_update[%0d]: got %b want 0", i, moved); end
        end
    endtask

    // Signed/unsigned divide, divide by zero and signed overflow.
    task automatic test_divide();
        logic [2:0]  t_op [6] = '{DIV, DIVU, DIV, DIV, DIVU, DIV};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] t_b  [6] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE};
        int          exp_cyc;
        int          cyc;
        logic        busy_seen;
        logic        moved;
        for (int i = 0; i < 6; i++) begin
            exp_cyc = model_exec(t_op[i], t_a[i], t_b[i]);
            run_op(t_op[i], t_a[i], t_b[i], 0, '0, cyc, busy_seen, moved);
            n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("[TB] FAIL div_latency[%0d]: got %0d want %0d", i, cyc, exp_cyc); end
            n_checks++; if (Hi !== model_hi) begin n_fail++; $display("[TB] FAIL div_hi[%0d]: got %h want %h", i, Hi, model_hi); end
            n_checks++; if (Lo !== model_lo) begin n_fail++; $display("[TB] FAIL div_lo[%0d]: got %h want %h", i, Lo, model_lo); end
            n_checks++; if (busy_seen !== (exp_cyc != 1)) begin n_fail++; $display("[TB] FAIL div_busy[%0d]: got %b want %b", i, busy_seen, (exp_cyc != 1)); end
        end
    endtask

    // Start while busy is ignored; reset mid-operation aborts with no Done.
    task automatic test_busy_ignore_and_reset();
        int   exp_cyc;
        int   cyc;
        logic busy_seen;
        logic moved;
        logic done_seen;
        exp_cyc = model_exec(MULT, 32'd3, 32'd3);
        run_op(MULT, 32'd3, 32'd3, 5, 32'd9, cyc, busy_seen, moved);
        n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("[TB] FAIL ignore_latency: got %0d want %0d", cyc, exp_cyc); end
        n_checks++; if (Lo !== 32'd9)    begin n_fail++; $display("[TB] FAIL ignore_lo: got %h want %h", Lo, 32'd9); end
        n_checks++; if (Hi !== 32'd0)    begin n_fail++; $display("[TB] FAIL ignore_hi: got %h want %h", Hi, 32'd0); end
        n_checks++; if (moved !== 1'b0)  begin n_fail++; $display("[TB] FAIL ignore_early_update: got %b want 0", moved); end

        Start = 1'b1;
        Op    = MULT;
        A     = 32'd123;
        B     = 32'd456;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy_before: got %b want 1", Busy); end
        Rst = 1'b1;
        #1;
        n_checks++; if (Hi !== 32'd0)  begin n_fail++; $display("[TB] FAIL abort_hi: got %h want %h", Hi, 32'd0); end
        n_checks++; if (Lo !== 32'd0)  begin n_fail++; $display("[TB] FAIL abort_lo: got %h want %h", Lo, 32'd0); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b want 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got %b want 0", Done); end
        @(posedge Clk); #1;
        Rst      = 1'b0;
        model_hi = '0;
        model_lo = '0;
        done_seen = 1'b0;
        repeat (ITER_LAT + 4) begin
            @(posedge Clk); #1;
            if (Done === 1'b1 || Busy === 1'b1) done_seen = 1'b1;
        end
        n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_done: got %b want 0", done_seen); end
        n_checks++; if (Lo !== 32'd0) begin n_fail++; $display("[TB] FAIL abort_lo_after: got %h want %h", Lo, 32'd0); end
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Random op stream; each request is issued in the Done cycle of the last.
    task automatic test_random_back_to_back();
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               exp_cyc;
        int               cyc;
        logic             busy_seen;
        logic             moved;
        for (int i = 0; i < 60; i++) begin
            op      = 3'($urandom_range(0, 7));
            a       = pick_operand();
            b       = pick_operand();
            exp_cyc = model_exec(op, a, b);
            run_op(op, a, b, 0, '0, cyc, busy_seen, moved);
            n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("[TB] FAIL rnd_latency[%0d] op=%0d: got %0d want %0d", i, op, cyc, exp_cyc); end
            n_checks++; if (Hi !== model_hi) begin n_fail++; $display("[TB] FAIL rnd_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, Hi, model_hi); end
            n_checks++; if (Lo !== model_lo) begin n_fail++; $display("[TB] FAIL rnd_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, Lo, model_lo); end
            n_checks++; if (moved !== 1'b0)  begin n_fail++; $display("[TB] FAIL rnd_early_update[%0d]: got %b want 0", i, moved); end
        end
    endtask

    initial begin
        $display("[TB] hilo_muldiv_unit bench start");
        test_reset();
        test_mult_directed();
        test_divide();
        test_busy_ignore_and_reset();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width; legal range is any even value from 8 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 Clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  operation request; sampled only when Busy=0.
REQ-006 Op  input  3  operation code: MULT=000, MULTU=001, MADD=010, MSUB=011, DIV=100, DIVU=101, MTHI=110, MTLO=111.
REQ-007 A, B  input  WIDTH each  operands: multiplicand/dividend A, multiplier/divisor B; MTHI/MTLO use A.
REQ-008 Hi, Lo  output  WIDTH each  architectural HI/LO registers, driven directly from flops.
REQ-009 Busy  output  1  high while an iterative operation is in flight.
REQ-010 Done  output  1  one-cycle pulse when Hi/Lo hold a newly completed result.

Function
REQ-011 FSM states: IDLE, RUN, FIX; reset state is IDLE.
REQ-012 IDLE with Start=1 and Op=MTHI/MTLO: Hi (or Lo) <= A at that edge; Done pulses the next cycle; the FSM stays in IDLE.
REQ-013 IDLE with Start=1 and any other Op: latch operand magnitudes, signs and Op; counter <= WIDTH; go to RUN; Busy=1 from the next cycle.
REQ-014 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); decrement the counter; go to FIX when it reaches 1.
REQ-015 FIX: apply sign correction, write Hi/Lo, clear Busy; go to IDLE; Done=1 in the cycle after FIX.
REQ-016 Latency is constant: Done asserts exactly WIDTH+2 cycles after the accepting edge, for all iterative ops including divide-by-zero.
REQ-017 MULT/MULTU: {Hi,Lo} <= the 2*WIDTH-bit signed/unsigned product.
REQ-018 MADD: {Hi,Lo} <= {Hi,Lo} + signed product; MSUB: {Hi,Lo} <= {Hi,Lo} - signed product; modulo 2^(2*WIDTH); the old {Hi,Lo} is the value at the accepting edge.
REQ-019 DIV/DIVU: Lo <= quotient, truncated toward zero; Hi <= remainder, whose sign follows the dividend.
REQ-020 Divide by zero: Lo <= all ones; Hi <= A.
REQ-021 Signed overflow (A=most-negative, B=-1): Lo <= A; Hi <= 0.
REQ-022 Start while Busy=1 is ignored; there is no queueing; Hi/Lo and the in-flight operation are unaffected.
REQ-023 Start in the same cycle as Done=1 is legal and accepted.
REQ-024 Hi/Lo change only at the FIX edge or an MTHI/MTLO edge; they never show intermediate values.

Reset
REQ-025 Rst=1 forces asynchronously: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, counter=0.
REQ-026 Rst mid-operation aborts the operation; no Done is produced; the partial result is discarded.

Configuration
REQ-027 Macro HILO_MULDIV_DIV_EN defined: DIV/DIVU are implemented per REQ-019..021.
REQ-028 HILO_MULDIV_DIV_EN undefined: no divider datapath is present; DIV/DIVU are accepted, leave Hi/Lo unchanged, and pulse Done the next cycle with Busy never asserted.

Structure
REQ-029 Package muldiv_pkg holds: the Op code localparams, the FSM state typedef (IDLE/RUN/FIX), and the div-by-zero/overflow result constants.
REQ-030 Sub-module muldiv_step holds the combinational single-iteration datapath (add/shift or trial-subtract); hilo_muldiv_unit owns the FSM, counter, sign fix and Hi/Lo.

Verification (WIDTH=32)
REQ-031 MULT A=0xFFFFFFFD, B=7 -> Done at cycle 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-032 MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; then MTLO A=10, MTHI A=0, MADD A=4, B=5 -> Lo=30, Hi=0; MSUB A=4, B=5 -> Lo=10.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=7, B=2 -> Lo=3, Hi=1.
REQ-034 DIV A=5, B=0 -> Lo=0xFFFFFFFF, Hi=5 after 34 cycles; DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-035 MULT 3x3, with Start pulsed at cycle 5 (MTHI A=9) and Rst pulsed at cycle 10 of a second MULT -> the first MULT gives Lo=9 with Hi unaffected by the ignored MTHI; after Rst, Hi=Lo=0, no Done, Busy=0.
